// File: rtl/tile_map_renderer.sv
// tile_map_renderer: turns the VGA scan position into a tile-map lookup, a glyph-sheet
// ROM fetch and a registered 12-bit RGB pixel, through a 4-stage pipeline that
// advances only on pix_en.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pix_en              pixel clock enable; every register holds while low
//   hcount, vcount      scan position (visible area 0..639 x 0..479)
//   video_on            high inside the visible area
//   map_addr/map_dout   tile-map RAM read port (1-cycle registered read)
//   rom_addr/rom_data   glyph-sheet ROM read port (1-cycle registered read)
//   rgb, rgb_valid      output pixel and its visible-area flag
// Optional build macro: TILE_TRANSPARENCY_EN makes KEY_COLOR glyph pixels show BG_COLOR.
module tile_map_renderer #(
    parameter int          MAP_COLS  = 40,
    parameter int          MAP_ROWS  = 30,
    parameter logic [11:0] BG_COLOR  = 12'h000,
    parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        video_on,
    output logic [15:0] map_addr,
    input  logic [15:0] map_dout,
    output logic [16:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic [11:0] rgb,
    output logic        rgb_valid
);
    localparam logic [9:0] H_VIS = 10'(MAP_COLS * 16);
    localparam logic [9:0] V_VIS = 10'(MAP_ROWS * 16);
    logic [3:0]  xoff0, yoff0, xoff1, yoff1;
    logic        von0, von1, von2, von3, empty2, empty3;
    logic [15:0] tile_idx;
    logic [11:0] pix;
    logic        unused_bits;
    // Off-screen coordinates still issue a read, but of entry 0; video_on masks the result.
    always_comb tile_idx = (hcount < H_VIS && vcount < V_VIS) ?
                           16'(vcount[9:4]) * 16'(MAP_COLS) + 16'(hcount[9:4]) : '0;
`ifdef TILE_TRANSPARENCY_EN
    always_comb pix = (rom_data == KEY_COLOR) ? BG_COLOR : rom_data;
`else
    always_comb pix = rom_data;
`endif
    assign unused_bits = ^{map_dout[14:9], KEY_COLOR};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_addr  <= '0;
            rom_addr  <= '0;
            rgb       <= BG_COLOR;
            rgb_valid <= 1'b0;
            {xoff0, yoff0, xoff1, yoff1} <= '0;
            {von0, von1, von2, von3, empty2, empty3} <= '0;
        end else if (pix_en) begin
            map_addr  <= tile_idx;
            xoff0     <= hcount[3:0];
            yoff0     <= vcount[3:0];
            von0      <= video_on;
            xoff1     <= xoff0;
            yoff1     <= yoff0;
            von1      <= von0;
            // Entry fields: bank[8:6], sheet row[5:3], sheet col[2:0]; bit 15 marks an empty tile.
            rom_addr  <= {map_dout[8:6], map_dout[5:3], yoff1, map_dout[2:0], xoff1};
            empty2    <= map_dout[15];
            von2      <= von1;
            empty3    <= empty2;
            von3      <= von2;
            rgb       <= (!von3 || empty3) ? BG_COLOR : pix;
            rgb_valid <= von3;
        end
    end
endmodule

// File: tb/tb_tile_map_renderer.sv
// tb_tile_map_renderer: directed and randomized checks of tile_map_renderer against
// a behavioural model built from the tile-map/glyph-sheet addressing rules.
module tb_tile_map_renderer;
    localparam logic [11:0] BG = 12'h000;
    logic        clk = 0, rst_n = 0, pix_en = 0, video_on = 0;
    logic [9:0]  hcount = 0, vcount = 0;
    logic [15:0] map_addr, map_dout;
    logic [16:0] rom_addr;
    logic [11:0] rom_data, rgb;
    logic        rgb_valid;
    logic [15:0] map_mem [65536];
    logic [11:0] rom_mem [131072];
    logic [15:0] e_map [4096];
    logic [16:0] e_rom [4096];
    logic [11:0] e_rgb [4096];
    logic        e_v   [4096];
    int          n = 0, checks = 0, errors = 0;

    tile_map_renderer dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
        .video_on(video_on), .map_addr(map_addr), .map_dout(map_dout),
        .rom_addr(rom_addr), .rom_data(rom_data), .rgb(rgb), .rgb_valid(rgb_valid)
    );

    always #5 clk = ~clk;

    // Registered-read memories whose read enables follow pix_en.
    always @(posedge clk) if (pix_en) begin
        map_dout <= map_mem[map_addr];
        rom_data <= rom_mem[rom_addr];
    end

    function automatic logic [15:0] m_map(int h, int v);
        return (h < 640 && v < 480) ? 16'((v / 16) * 40 + h / 16) : 16'd0;
    endfunction

    function automatic logic [16:0] m_rom(int h, int v);
        logic [15:0] e;
        e = map_mem[m_map(h, v)];
        return {e[8:6], e[5:3], 4'(v % 16), e[2:0], 4'(h % 16)};
    endfunction

    function automatic logic [11:0] m_rgb(int h, int v, bit von);
        logic [15:0] e;
        logic [11:0] p;
        e = map_mem[m_map(h, v)];
        p = rom_mem[m_rom(h, v)];
`ifdef TILE_TRANSPARENCY_EN
        if (p == 12'hF0F) p = BG;
`endif
        return (!von || e[15]) ? BG : p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int h, input int v, input bit von, input bit en);
        logic [15:0] pm;
        logic [16:0] pr;
        logic [11:0] prgb;
        logic        pv;
        hcount = 10'(h); vcount = 10'(v); video_on = von; pix_en = en;
        pm = map_addr; pr = rom_addr; prgb = rgb; pv = rgb_valid;
        if (en) begin
            n++;
            e_map[n] = m_map(h, v);
            e_rom[n] = m_rom(h, v);
            e_rgb[n] = m_rgb(h, v, von);
            e_v[n]   = von;
        end
        @(posedge clk);
        #1;
        if (en) begin
            check("map_addr", 32'(map_addr), 32'(e_map[n]));
            if (n > 2) check("rom_addr", 32'(rom_addr), 32'(e_rom[n-2]));
            check("rgb", 32'(rgb), 32'(n > 4 ? e_rgb[n-4] : BG));
            check("rgb_valid", 32'(rgb_valid), 32'(n > 4 ? e_v[n-4] : 1'b0));
        end else begin
            check("hold_map_addr", 32'(map_addr), 32'(pm));
            check("hold_rom_addr", 32'(rom_addr), 32'(pr));
            check("hold_rgb", 32'(rgb), 32'(prgb));
            check("hold_rgb_valid", 32'(rgb_valid), 32'(pv));
        end
    endtask

    initial begin
        int h, v;
        for (int i = 0; i < 65536; i++) map_mem[i] = 16'($urandom);
        for (int i = 0; i < 131072; i++) rom_mem[i] = ($urandom_range(0, 15) == 0) ? 12'hF0F : 12'($urandom);
        map_mem[0]   = 16'h0000;
        rom_mem[0]   = 12'hABC;
        map_mem[122] = {7'b0, 3'b100, 3'd1, 3'd7};
        map_mem[7]   = 16'h8000;
        map_mem[5]   = {7'b0, 3'd2, 3'd3, 3'd4};
        rom_mem[m_rom(83, 1)] = 12'hF0F;
        rom_mem[m_rom(84, 1)] = 12'hF0E;
        #23;
        check("reset_rgb", 32'(rgb), 32'(BG));
        check("reset_rgb_valid", 32'(rgb_valid), 32'd0);
        check("reset_map_addr", 32'(map_addr), 32'd0);
        check("reset_rom_addr", 32'(rom_addr), 32'd0);
        rst_n = 1;
        @(posedge clk);
        #1;
        step(0, 0, 1, 1);
        step(37, 50, 1, 1);
        step(1, 0, 1, 1);
        step(2, 0, 1, 1);
        check("rom_addr_37_50", 32'(rom_addr), 32'h10975);
        step(3, 0, 1, 1);
        check("first_pixel_rgb", 32'(rgb), 32'hABC);
        check("first_pixel_valid", 32'(rgb_valid), 32'd1);
        step(112, 0, 1, 1);
        step(113, 0, 1, 1);
        step(114, 0, 0, 1);
        step(115, 0, 1, 1);
        step(83, 1, 1, 1);
        step(84, 1, 1, 1);
        step(85, 1, 1, 0);
        step(85, 1, 1, 0);
        step(85, 1, 1, 1);
        step(700, 500, 0, 1);
        step(640, 10, 0, 1);
        for (int i = 0; i < 5; i++) step(16 * i, 16, 1, 1);
        #2;
        rst_n = 0;
        #1;
        check("async_rgb", 32'(rgb), 32'(BG));
        check("async_rgb_valid", 32'(rgb_valid), 32'd0);
        check("async_map_addr", 32'(map_addr), 32'd0);
        check("async_rom_addr", 32'(rom_addr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
        n = 0;
        for (int i = 0; i < 600; i++) begin
            h = $urandom_range(0, 799);
            v = $urandom_range(0, 524);
            step(h, v, (h < 640 && v < 480) && ($urandom_range(0, 9) != 0), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
